// File: rtl/exec_alu_pipe.sv
// Execution unit: single-cycle ALU ops plus a bit-serial multiplier, with a
// valid/ready handshake on both sides and one registered result slot.
//
// state | meaning
// IDLE  | no result held, ready for a request
// MUL   | multiplier iterating one multiplier bit per cycle
// DONE  | result held on out_*, waiting for out_ready
module exec_alu_pipe #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [5:0]       in_flags,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_val,
   output logic [5:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic             busy
);
   localparam int SW = $clog2(WIDTH);
   localparam int M  = WIDTH - 1;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   state_t state, state_nxt;

   logic             accept, is_mul;
   logic [WIDTH-1:0] alu_val;
   logic [5:0]       alu_flags;
   logic             alu_err;

   logic [WIDTH:0]   sum, dif, shl_x, shr_x, sar_x;
   logic [SW-1:0]    sh;
   logic [WIDTH-1:0] r;
   logic             cf, of, af, keep_flags;

   logic [WIDTH-1:0]   mul_a, mul_b;
   logic [2*WIDTH-1:0] mul_p, p_nxt;
   logic [WIDTH:0]     mul_sum;
   logic [1:0]         mul_op;
   logic [SW-1:0]      mul_cnt;
   logic [WIDTH-1:0]   u_hi, s_hi, lo, mul_res;
   logic               mul_ov;

   assign accept    = in_valid && in_ready;
   assign is_mul    = (in_op == 4'd9) || (in_op == 4'd10) || (in_op == 4'd11);
   assign out_valid = (state == DONE);

   always_comb begin
      sh    = in_b[SW-1:0];
      sum   = {1'b0, in_a} + {1'b0, in_b};
      dif   = {1'b0, in_a} - {1'b0, in_b};
      // extra bit on the shifted-out side captures the last bit lost
      shl_x = {1'b0, in_a} << sh;
      shr_x = {in_a, 1'b0} >> sh;
      sar_x = $unsigned($signed({in_a, 1'b0}) >>> sh);
      r          = '0;
      cf         = 1'b0;
      of         = 1'b0;
      af         = 1'b0;
      keep_flags = 1'b0;
      alu_err    = 1'b0;
      case (in_op)
         4'd0: begin
            r  = sum[M:0];
            cf = sum[WIDTH];
            of = (in_a[M] == in_b[M]) && (r[M] != in_a[M]);
            af = in_a[4] ^ in_b[4] ^ r[4];
         end
         4'd1: begin
            r  = dif[M:0];
            cf = dif[WIDTH];
            of = (in_a[M] != in_b[M]) && (r[M] != in_a[M]);
            af = in_a[4] ^ in_b[4] ^ r[4];
         end
         4'd2: r = in_a & in_b;
         4'd3: r = in_a | in_b;
         4'd4: r = in_a ^ in_b;
         4'd5: begin
            r  = shl_x[M:0];
            cf = shl_x[WIDTH];
            of = (sh == SW'(1)) && (r[M] ^ cf);
         end
         4'd6: begin
            r  = shr_x[WIDTH:1];
            cf = shr_x[0];
            of = (sh == SW'(1)) && in_a[M];
         end
         4'd7: begin
            r  = sar_x[WIDTH:1];
            cf = sar_x[0];
         end
         4'd8:                 keep_flags = 1'b1;
         4'd9, 4'd10, 4'd11:   r = '0;
         default:              alu_err = 1'b1;
      endcase
      if ((in_op == 4'd5 || in_op == 4'd6 || in_op == 4'd7) && sh == '0)
         keep_flags = 1'b1;
      if (in_op == 4'd8 || keep_flags)
         r = in_a;
      alu_val = r;
      if (keep_flags)
         alu_flags = in_flags;
      else if (alu_err)
         alu_flags = '0;
      else
         alu_flags = {of, r[M], (r == '0), af, ~^r[7:0], cf};
   end

   // unsigned shift-add; signed results are corrected from the unsigned high half
   always_comb begin
      mul_sum = {1'b0, mul_p[2*WIDTH-1:WIDTH]} + (mul_p[0] ? {1'b0, mul_a} : '0);
      p_nxt   = {mul_sum, mul_p[M:1]};
      u_hi    = p_nxt[2*WIDTH-1:WIDTH];
      lo      = p_nxt[M:0];
      s_hi    = u_hi - (mul_a[M] ? mul_b : '0) - (mul_b[M] ? mul_a : '0);
      mul_ov  = (mul_op == 2'd3) ? (u_hi != '0) : (s_hi != {WIDTH{lo[M]}});
      case (mul_op)
         2'd1:    mul_res = lo;
         2'd2:    mul_res = s_hi;
         default: mul_res = u_hi;
      endcase
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = is_mul ? MUL : DONE;
         end
         MUL: begin
            busy = 1'b1;
            if (mul_cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) state_nxt = in_valid ? (is_mul ? MUL : DONE) : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         out_val   <= '0;
         out_flags <= '0;
         out_tag   <= '0;
         out_err   <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_p     <= '0;
         mul_op    <= '0;
         mul_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            out_tag <= in_tag;
            if (is_mul) begin
               mul_a   <= in_a;
               mul_b   <= in_b;
               mul_p   <= {{WIDTH{1'b0}}, in_b};
               mul_op  <= in_op[1:0];
               mul_cnt <= SW'(WIDTH - 1);
            end else begin
               out_val   <= alu_val;
               out_flags <= alu_flags;
               out_err   <= alu_err;
            end
         end else if (state == MUL) begin
            mul_p   <= p_nxt;
            mul_cnt <= mul_cnt - SW'(1);
            if (mul_cnt == '0) begin
               out_val   <= mul_res;
               out_flags <= {mul_ov, 4'b0000, mul_ov};
               out_err   <= 1'b0;
            end
         end
      end
   end
endmodule
